// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller around a single full-adder cell
// One operand bit per cycle, LSB first; results are registered and held until the next finished add.
module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [N-1:0]   sa_q, sb_q, sh_q, sum_q;
    logic [CW-1:0]  cnt_q;
    logic           cy_q, c_out_q, ovf_q;
    logic           ready_q, busy_q, done_q;

    logic           fa_s, fa_c, last;
    logic [N-1:0]   sa_d, sb_d, sh_d;

    always_comb begin
        fa_s = sa_q[0] ^ sb_q[0] ^ cy_q;
        fa_c = (sa_q[0] & sb_q[0]) | (sa_q[0] & cy_q) | (sb_q[0] & cy_q);
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        // Shift path is separate from sum_q so the visible result stays put during an add.
        sh_d = sh_q >> 1;
        sh_d[N-1] = fa_s;
        last = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        cy_q    <= c_in;
                        cnt_q   <= '0;
                        state_q <= ADD;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ADD: begin
                    sa_q  <= sa_d;
                    sb_q  <= sb_d;
                    sh_q  <= sh_d;
                    cy_q  <= fa_c;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        // cy_q here is the carry into the MSB, fa_c the carry out of it.
                        sum_q   <= sh_d;
                        c_out_q <= fa_c;
                        ovf_q   <= cy_q ^ fa_c;
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - randomized self-checking bench for serial_adder_ctrl at N=8, 1 and 32
module tb_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        c_in;
    logic        st8, st1, st32;

    always #5 clk = ~clk;

    logic       r8, bz8, d8, co8, ov8;
    logic [7:0] s8;
    logic       r1, bz1, d1, co1, ov1;
    logic [0:0] s1;
    logic       r32, bz32, d32, co32, ov32;
    logic [31:0] s32;

    serial_adder_ctrl #(.N(8)) u_n8 (
        .clk(clk), .rst(rst), .start(st8), .a(a[7:0]), .b(b[7:0]), .c_in(c_in),
        .ready(r8), .busy(bz8), .done(d8), .sum(s8), .c_out(co8), .overflow(ov8)
    );
    serial_adder_ctrl #(.N(1)) u_n1 (
        .clk(clk), .rst(rst), .start(st1), .a(a[0:0]), .b(b[0:0]), .c_in(c_in),
        .ready(r1), .busy(bz1), .done(d1), .sum(s1), .c_out(co1), .overflow(ov1)
    );
    serial_adder_ctrl #(.N(32)) u_n32 (
        .clk(clk), .rst(rst), .start(st32), .a(a), .b(b), .c_in(c_in),
        .ready(r32), .busy(bz32), .done(d32), .sum(s32), .c_out(co32), .overflow(ov32)
    );

    int          sel = 8;
    logic        o_rdy, o_busy, o_done, o_co, o_ov;
    logic [31:0] o_sum;

    always_comb begin
        o_rdy = r8; o_busy = bz8; o_done = d8; o_co = co8; o_ov = ov8; o_sum = {24'b0, s8};
        case (sel)
            1:  begin o_rdy = r1;  o_busy = bz1;  o_done = d1;  o_co = co1;  o_ov = ov1;  o_sum = {31'b0, s1}; end
            32: begin o_rdy = r32; o_busy = bz32; o_done = d32; o_co = co32; o_ov = ov32; o_sum = s32; end
            default: ;
        endcase
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        st8 = 1'b0; st1 = 1'b0; st32 = 1'b0;
        case (sel)
            1:       st1  = v;
            32:      st32 = v;
            default: st8  = v;
        endcase
    endtask

    // Reference: plain modulo arithmetic; carry into the MSB from the sum of the low N-1 bits.
    function automatic logic [33:0] ref_add(input int n, input logic [31:0] x, input logic [31:0] y,
                                            input logic ci);
        longint m, m1, full, low;
        logic   cout, cmsb;
        m    = (longint'(1) << n) - 1;
        m1   = (longint'(1) << (n - 1)) - 1;
        full = (longint'(x) & m) + (longint'(y) & m) + longint'(ci);
        low  = (longint'(x) & m1) + (longint'(y) & m1) + longint'(ci);
        cout = ((full >> n) & 1) != 0;
        cmsb = ((low >> (n - 1)) & 1) != 0;
        return {cmsb ^ cout, cout, 32'(full & m)};
    endfunction

    // Entered just after the accepting edge; checks latency and the registered results.
    task automatic finish_add(input int n, input string tag, input logic [33:0] exp);
        int edges = 0;
        check({tag, " busy"}, o_busy, 1);
        check({tag, " ready"}, o_rdy, 0);
        while (!o_done && edges < n + 4) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, " latency"}, edges, n);
        check({tag, " sum"}, o_sum, exp[31:0]);
        check({tag, " c_out"}, o_co, exp[32]);
        check({tag, " ovf"}, o_ov, exp[33]);
        check({tag, " ready_done"}, o_rdy, 1);
    endtask

    task automatic run_add(input int s, input int n, input logic [31:0] x, input logic [31:0] y,
                           input logic ci, input string tag);
        logic [33:0] exp;
        sel = s;
        exp = ref_add(n, x, y, ci);
        a = x; b = y; c_in = ci;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        a = $urandom; b = $urandom; c_in = 1'($urandom);
        finish_add(n, tag, exp);
        @(posedge clk); #1;
        check({tag, " pulse"}, o_done, 0);
    endtask

    initial begin
        logic [33:0] e1, e2;
        int nd;
        rst = 1'b1; a = '0; b = '0; c_in = 1'b0;
        st8 = 1'b0; st1 = 1'b0; st32 = 1'b0;
        #12;
        check("rst ready", r8, 1);
        check("rst busy", bz8, 0);
        check("rst done", d8, 0);
        check("rst sum", s8, 0);
        check("rst cout", co8, 0);
        check("rst ovf", ov8, 0);
        check("rst sum32", s32, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_add(8, 8, 32'h5A, 32'h3C, 1'b0, "5a3c");
        run_add(8, 8, 32'hFF, 32'h01, 1'b0, "ff01");
        run_add(8, 8, 32'h80, 32'h80, 1'b0, "8080");
        run_add(8, 8, 32'h00, 32'h00, 1'b1, "cin");
        for (int i = 0; i < 10; i++) run_add(8, 8, $urandom, $urandom, 1'($urandom), "rnd8");

        // Start pulsed mid-add must be ignored; then a start held in DONE chains back-to-back.
        sel = 8;
        e1 = ref_add(8, 32'h5A, 32'h3C, 1'b0);
        a = 32'h5A; b = 32'h3C; c_in = 1'b0;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        nd = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin
                a = 32'hFF; b = 32'hFF; c_in = 1'b1;
                set_start(1'b1);
            end else if (i == 4) begin
                set_start(1'b0);
            end
            @(posedge clk); #1;
            if (o_done) nd++;
        end
        check("ign done", o_done, 1);
        check("ign sum", o_sum, e1[31:0]);
        check("ign cout", o_co, e1[32]);
        check("ign ovf", o_ov, e1[33]);
        a = 32'hC3; b = 32'h71; c_in = 1'b1;
        e2 = ref_add(8, 32'hC3, 32'h71, 1'b1);
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        check("ign pulses", nd, 1);
        check("b2b done", o_done, 0);
        check("b2b held", o_sum, e1[31:0]);
        finish_add(8, "b2b", e2);

        // Asynchronous reset between edges in the middle of an add.
        a = 32'h11; b = 32'h22; c_in = 1'b0;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst ready", o_rdy, 1);
        check("arst busy", o_busy, 0);
        check("arst done", o_done, 0);
        check("arst sum", o_sum, 0);
        check("arst cout", o_co, 0);
        check("arst ovf", o_ov, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (o_done) nd++;
        end
        check("arst nodone", nd, 0);
        run_add(8, 8, 32'h5A, 32'h3C, 1'b0, "post_rst");

        run_add(1, 1, 32'h1, 32'h0, 1'b0, "n1_10");
        run_add(1, 1, 32'h5A, 32'h3C, 1'b0, "n1_5a3c");
        for (int i = 0; i < 6; i++) run_add(1, 1, $urandom, $urandom, 1'($urandom), "rnd1");

        run_add(32, 32, 32'h8000_0000, 32'h8000_0000, 1'b0, "n32_min");
        run_add(32, 32, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, "n32_max");
        for (int i = 0; i < 20; i++) run_add(32, 32, $urandom, $urandom, 1'($urandom), "rnd32");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
